// File: rtl/spi_master.sv
// Mode-0 SPI master (CPOL=0, CPHA=0, MSB first) feeding the on-chip SPI slave
// on the same clock domain. Bytes enter through a one-entry valid/ready holding
// register; a byte flagged tx_last closes the frame.
//
// Optional feature macro: SPI_MASTER_RX_EN. When it is defined, MISO is captured
// and returned on rx_data/rx_valid. When it is not defined, rx_data is 0x00 and
// rx_valid is 0.
//
// Parameters : CLK_DIV  SCK half-period in clk cycles (4..255)
//              CS_SETUP SSEL fall to first SCK rise, in clk cycles
//              CS_HOLD  last SCK fall to SSEL rise, in clk cycles
//              CS_IDLE  minimum SSEL-high cycles between frames
// Ports      : clk, rst (sync, active-high)
//              tx_data/tx_last/tx_valid/tx_ready  byte stream in
//              rx_data/rx_valid                   received byte strobe
//              busy                               state is not IDLE
//              SCK/SSEL/MOSI/MISO                 SPI pins
module spi_master #(
    parameter int unsigned CLK_DIV  = 4,
    parameter int unsigned CS_SETUP = 4,
    parameter int unsigned CS_HOLD  = 4,
    parameter int unsigned CS_IDLE  = 8
) (
    input  logic       clk,
    input  logic       rst,
    input  logic [7:0] tx_data,
    input  logic       tx_last,
    input  logic       tx_valid,
    output logic       tx_ready,
    output logic [7:0] rx_data,
    output logic       rx_valid,
    output logic       busy,
    output logic       SCK,
    output logic       SSEL,
    output logic       MOSI,
    input  logic       MISO
);

    localparam int unsigned MAX_A   = (CLK_DIV > CS_SETUP) ? CLK_DIV : CS_SETUP;
    localparam int unsigned MAX_B   = (CS_HOLD > CS_IDLE) ? CS_HOLD : CS_IDLE;
    localparam int unsigned CNT_MAX = (MAX_A > MAX_B) ? MAX_A : MAX_B;
    localparam int unsigned CNT_W   = (CNT_MAX > 1) ? $clog2(CNT_MAX) : 1;

    typedef enum logic [2:0] {
        IDLE,
        SETUP,
        XFER,
        STALL,
        HOLD,
        GAP
    } state_e;

    state_e             state_q;
    logic [CNT_W-1:0]   cnt_q;
    logic [2:0]         bit_cnt_q;
    logic [6:0]         tx_shift_q;
    logic               cur_last_q;
    logic               armed_q;
    logic               sck_q;
    logic               ssel_q;
    logic               mosi_q;
    logic               busy_q;
    logic               full_q;
    logic [7:0]         hold_data_q;
    logic               hold_last_q;

    logic               phase_end_c;
    logic               rise_c;
    logic               fall_c;
    logic               byte_end_c;
    logic               load_c;
    logic               accept_c;

    // Timing events derived from the current state and counters
    always_comb begin
        phase_end_c = (cnt_q == CNT_W'(CLK_DIV - 1));
        rise_c      = ((state_q == SETUP) && (cnt_q == CNT_W'(CS_SETUP - 1)))
                   || ((state_q == XFER) && !sck_q && phase_end_c)
                   || ((state_q == STALL) && armed_q && phase_end_c);
        fall_c      = (state_q == XFER) && sck_q && phase_end_c;
        // bit counter has wrapped to 0 after the 8th rise, so this fall is the 8th
        byte_end_c  = fall_c && (bit_cnt_q == 3'd0);
        load_c      = ((state_q == IDLE) && full_q)
                   || (byte_end_c && !cur_last_q && full_q)
                   || ((state_q == STALL) && !armed_q && full_q);
        accept_c    = tx_valid && !full_q;
    end

    // One-entry holding register between the stream and the shifter
    always_ff @(posedge clk) begin
        if (rst) begin
            full_q      <= 1'b0;
            hold_data_q <= 8'h00;
            hold_last_q <= 1'b0;
        end else begin
            if (accept_c) begin
                hold_data_q <= tx_data;
                hold_last_q <= tx_last;
            end
            full_q <= accept_c || (full_q && !load_c);
        end
    end

    // Frame sequencer; every SPI pin is driven straight from a register
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q    <= IDLE;
            cnt_q      <= '0;
            bit_cnt_q  <= 3'd0;
            tx_shift_q <= 7'd0;
            cur_last_q <= 1'b0;
            armed_q    <= 1'b0;
            sck_q      <= 1'b0;
            ssel_q     <= 1'b1;
            mosi_q     <= 1'b0;
            busy_q     <= 1'b0;
        end else begin
            // a load always presents bit7 immediately, whichever state loads
            if (load_c) begin
                tx_shift_q <= hold_data_q[6:0];
                mosi_q     <= hold_data_q[7];
                cur_last_q <= hold_last_q;
            end
            unique case (state_q)
                IDLE: begin
                    if (full_q) begin
                        ssel_q    <= 1'b0;
                        busy_q    <= 1'b1;
                        cnt_q     <= '0;
                        bit_cnt_q <= 3'd0;
                        state_q   <= SETUP;
                    end
                end
                SETUP: begin
                    if (rise_c) begin
                        sck_q     <= 1'b1;
                        cnt_q     <= '0;
                        bit_cnt_q <= bit_cnt_q + 3'd1;
                        state_q   <= XFER;
                    end else begin
                        cnt_q <= cnt_q + CNT_W'(1);
                    end
                end
                XFER: begin
                    if (rise_c) begin
                        sck_q     <= 1'b1;
                        cnt_q     <= '0;
                        bit_cnt_q <= bit_cnt_q + 3'd1;
                    end else if (byte_end_c) begin
                        sck_q <= 1'b0;
                        cnt_q <= '0;
                        if (cur_last_q) begin
                            // MOSI may only move on an SCK fall, so park it now
                            mosi_q  <= 1'b0;
                            state_q <= HOLD;
                        end else if (!full_q) begin
                            armed_q <= 1'b0;
                            state_q <= STALL;
                        end
                    end else if (fall_c) begin
                        sck_q      <= 1'b0;
                        cnt_q      <= '0;
                        mosi_q     <= tx_shift_q[6];
                        tx_shift_q <= {tx_shift_q[5:0], 1'b0};
                    end else begin
                        cnt_q <= cnt_q + CNT_W'(1);
                    end
                end
                STALL: begin
                    if (!armed_q) begin
                        if (full_q) begin
                            armed_q <= 1'b1;
                            cnt_q   <= '0;
                        end
                    end else if (rise_c) begin
                        sck_q     <= 1'b1;
                        cnt_q     <= '0;
                        bit_cnt_q <= bit_cnt_q + 3'd1;
                        armed_q   <= 1'b0;
                        state_q   <= XFER;
                    end else begin
                        cnt_q <= cnt_q + CNT_W'(1);
                    end
                end
                HOLD: begin
                    if (cnt_q == CNT_W'(CS_HOLD - 1)) begin
                        ssel_q  <= 1'b1;
                        cnt_q   <= '0;
                        state_q <= GAP;
                    end else begin
                        cnt_q <= cnt_q + CNT_W'(1);
                    end
                end
                GAP: begin
                    if (cnt_q == CNT_W'(CS_IDLE - 1)) begin
                        busy_q  <= 1'b0;
                        cnt_q   <= '0;
                        state_q <= IDLE;
                    end else begin
                        cnt_q <= cnt_q + CNT_W'(1);
                    end
                end
                default: state_q <= IDLE;
            endcase
        end
    end

`ifdef SPI_MASTER_RX_EN
    logic [6:0] rx_shift_q;
    logic [7:0] rx_data_q;
    logic       rx_valid_q;

    // MISO is in the same clock domain, so it is sampled directly on each rise
    always_ff @(posedge clk) begin
        if (rst) begin
            rx_shift_q <= 7'd0;
            rx_data_q  <= 8'h00;
            rx_valid_q <= 1'b0;
        end else begin
            rx_valid_q <= 1'b0;
            if (rise_c) begin
                rx_shift_q <= {rx_shift_q[5:0], MISO};
                if (bit_cnt_q == 3'd7) begin
                    rx_data_q  <= {rx_shift_q, MISO};
                    rx_valid_q <= 1'b1;
                end
            end
        end
    end

    assign rx_data  = rx_data_q;
    assign rx_valid = rx_valid_q;
`else
    logic unused_rx;
    assign unused_rx = MISO;
    assign rx_data   = 8'h00;
    assign rx_valid  = 1'b0;
`endif

    assign tx_ready = !full_q;
    assign busy     = busy_q;
    assign SCK      = sck_q;
    assign SSEL     = ssel_q;
    assign MOSI     = mosi_q;

endmodule
